// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared loader state encoding and word geometry.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    // States in which the loader holds in_ready high.
    function automatic logic accepts_byte(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : byte_packer
// Brief   : Big-endian byte-to-word shift register with word-complete flag.
// Revision: 1.0 - initial release
// ============================================================================
module byte_packer
    import mips_pkg::*;
(
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    i_shift,
    input  logic [7:0]              i_byte,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_word_full
);

    localparam int c_cnt_w = $clog2(WORD_BYTES);

    logic [8*WORD_BYTES-1:0] r_word;
    logic [c_cnt_w-1:0]      r_byte_cnt;

    // The counter wraps on the last byte, so it is ready for the next word.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
        end else if (i_shift) begin
            r_word     <= {r_word[8*WORD_BYTES-9:0], i_byte};
            r_byte_cnt <= r_byte_cnt + c_cnt_w'(1);
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_shift && (r_byte_cnt == c_cnt_w'(WORD_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module  : program_loader
// Brief   : Boot loader: byte stream -> 32-bit memory image, holds core in reset.
//           Optional trailing XOR checksum byte under LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module program_loader
    import mips_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] c_mem_words = 17'(MEM_WORDS);

    state_t      r_state;
    state_t      w_state_next;
    state_t      w_after_image;
    logic        r_in_ready;
    logic        r_mem_we;
    logic        r_cpu_rst;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [15:0] w_len;
    logic        w_xfer;
    logic        w_word_full;
    logic        w_last_word;
    logic [31:0] w_word;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_len       = {r_len[15:8], in_data};
    assign w_last_word = ({1'b0, r_word_idx} + 17'd1) >= {1'b0, r_len};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_chk;

    assign w_after_image = CHK;

    always_ff @(posedge clock) begin
        if (rst || (r_state == LEN_HI)) begin
            r_chk <= '0;
        end else if (w_xfer && (r_state == DATA)) begin
            r_chk <= r_chk ^ in_data;
        end
    end
`else
    assign w_after_image = DONE;
`endif

    byte_packer u_byte_packer (
        .clock       (clock),
        .rst         (rst),
        .i_shift     (w_xfer && (r_state == DATA)),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LEN_HI: if (w_xfer) w_state_next = LEN_LO;
            LEN_LO: begin
                if (w_xfer) begin
                    if (w_len == 16'd0)
                        w_state_next = w_after_image;
                    else if ({1'b0, w_len} > c_mem_words)
                        w_state_next = ERROR;
                    else
                        w_state_next = DATA;
                end
            end
            DATA:   if (w_word_full) w_state_next = WRITE;
            WRITE:  w_state_next = w_last_word ? w_after_image : DATA;
`ifdef LOADER_CHECKSUM_EN
            CHK:    if (w_xfer) w_state_next = (in_data == r_chk) ? DONE : ERROR;
`endif
            DONE:   if (reload) w_state_next = LEN_HI;
            ERROR:  w_state_next = ERROR;
            default: w_state_next = LEN_HI;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= LEN_HI;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_len      <= '0;
            r_word_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= accepts_byte(w_state_next);
            r_mem_we   <= (w_state_next == WRITE);
            r_done     <= (w_state_next == DONE);
            r_cpu_rst  <= (w_state_next != DONE);
            r_error    <= (w_state_next == ERROR);
            if (w_xfer && (r_state == LEN_HI)) r_len[15:8] <= in_data;
            if (w_xfer && (r_state == LEN_LO)) r_len[7:0]  <= in_data;
            if (r_state == WRITE)
                r_word_idx <= r_word_idx + 16'd1;
            else if ((r_state == DONE) && reload)
                r_word_idx <= '0;
        end
    end

    assign in_ready = r_in_ready;
    assign mem_we   = r_mem_we;
    assign mem_adr  = BASE_ADR + {14'd0, r_word_idx, 2'b00};
    assign mem_wd   = w_word;
    assign cpu_rst  = r_cpu_rst;
    assign done     = r_done;
    assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_loader
// Brief   : Self-checking bench for program_loader (table + random images).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_program_loader;

    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] BASE_ADR  = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    program_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADR(BASE_ADR)) dut (
        .clock    (clock),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .reload   (reload),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_wd   (mem_wd),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        rdy;
    } wr_t;

    wr_t        wr_log[$];
    int         xfer_cyc[$];
    logic [7:0] img[$];

    always @(negedge clock) begin
        if (mem_we === 1'b1) wr_log.push_back('{cyc, mem_adr, mem_wd, in_ready});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("rst in_ready", in_ready, 0);
        check("rst mem_we",   mem_we,   0);
        check("rst mem_adr",  mem_adr,  BASE_ADR);
        check("rst mem_wd",   mem_wd,   0);
        check("rst cpu_rst",  cpu_rst,  1);
        check("rst done",     done,     0);
        check("rst error",    error,    0);
        rst = 1'b0;
    endtask

    task automatic pulse_reload();
        in_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clock);
        reload   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit timed_out);
        int waited = 0;
        timed_out = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake: in_ready=%b expected 1 within 50 cycles", in_ready);
            in_valid  = 1'b0;
            timed_out = 1'b1;
        end else begin
            xfer_cyc.push_back(cyc + 1);
            @(negedge clock);
        end
    endtask

    task automatic build_image(input logic [15:0] n, input logic [31:0] w0,
                               input logic [31:0] w1, input bit rnd);
        logic [31:0] w;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
`endif
        img.delete();
        img.push_back(n[15:8]);
        img.push_back(n[7:0]);
        if (n <= MEM_WORDS) begin
            for (int j = 0; j < int'(n); j++) begin
                if (!rnd && j == 0)      w = w0;
                else if (!rnd && j == 1) w = w1;
                else                     w = $urandom;
                for (int k = 3; k >= 0; k--) begin
                    img.push_back(w[8*k +: 8]);
`ifdef LOADER_CHECKSUM_EN
                    x ^= w[8*k +: 8];
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            img.push_back(x);
`endif
        end
    endtask

    // Reference model: derive expected writes/status from the byte image itself.
    task automatic run_image(input int max_gap, input int reload_at);
        int  n;
        int  n_send;
        int  exp_nw;
        bit  too_big;
        bit  e_err;
        bit  aborted;
        wr_log.delete();
        xfer_cyc.delete();
        n       = int'({img[0], img[1]});
        too_big = (n > MEM_WORDS);
        n_send  = too_big ? 2 : 2 + 4 * n;
        exp_nw  = too_big ? 0 : n;
        e_err   = too_big;
`ifdef LOADER_CHECKSUM_EN
        if (!too_big) begin
            logic [7:0] x = 8'h00;
            for (int i = 2; i < n_send; i++) x ^= img[i];
            n_send++;
            if (img[n_send-1] !== x) e_err = 1'b1;
        end
`endif
        aborted = 1'b0;
        for (int i = 0; i < n_send && !aborted; i++) begin
            if (i == reload_at) pulse_reload();
            send_byte(img[i], int'($urandom_range(0, max_gap)), aborted);
        end
        // Stray bytes after the image must be ignored.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        repeat (4) @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        check("write count", wr_log.size(), exp_nw);
        for (int j = 0; j < exp_nw && j < wr_log.size(); j++) begin
            check("write adr", wr_log[j].adr, BASE_ADR + 32'(4 * j));
            check("write wd", wr_log[j].wd,
                  {img[2+4*j], img[3+4*j], img[4+4*j], img[5+4*j]});
            check("in_ready in WRITE", wr_log[j].rdy, 0);
            if (!aborted) check("write timing", wr_log[j].cyc, xfer_cyc[2+4*j+3]);
        end
        check("done",     done,     !e_err);
        check("error",    error,    e_err);
        check("cpu_rst",  cpu_rst,  e_err);
        check("in_ready idle", in_ready, 0);
    endtask

    typedef struct {
        logic [15:0] n;
        int          gap;
        bit          rnd;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          exp_done;
        bit          exp_err;
        int          exp_nw;
    } vec_t;

    vec_t vecs[7];
    bit   dummy;

    initial begin
        vecs[0] = '{n:16'd2,      gap:0, rnd:1'b0, w0:32'h20080005, w1:32'hAC080000, exp_done:1'b1, exp_err:1'b0, exp_nw:2};
        vecs[1] = '{n:16'd2,      gap:5, rnd:1'b0, w0:32'h20080005, w1:32'hAC080000, exp_done:1'b1, exp_err:1'b0, exp_nw:2};
        vecs[2] = '{n:16'h0101,   gap:0, rnd:1'b1, w0:32'h0,        w1:32'h0,        exp_done:1'b0, exp_err:1'b1, exp_nw:0};
        vecs[3] = '{n:16'h0000,   gap:0, rnd:1'b1, w0:32'h0,        w1:32'h0,        exp_done:1'b1, exp_err:1'b0, exp_nw:0};
        vecs[4] = '{n:16'd256,    gap:1, rnd:1'b1, w0:32'h0,        w1:32'h0,        exp_done:1'b1, exp_err:1'b0, exp_nw:256};
        vecs[5] = '{n:16'd1,      gap:3, rnd:1'b0, w0:32'hDEADBEEF, w1:32'h0,        exp_done:1'b1, exp_err:1'b0, exp_nw:1};
        vecs[6] = '{n:16'hFFFF,   gap:2, rnd:1'b1, w0:32'h0,        w1:32'h0,        exp_done:1'b0, exp_err:1'b1, exp_nw:0};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            build_image(vecs[i].n, vecs[i].w0, vecs[i].w1, vecs[i].rnd);
            run_image(vecs[i].gap, -1);
            check("tbl done",   done,          vecs[i].exp_done);
            check("tbl error",  error,         vecs[i].exp_err);
            check("tbl writes", wr_log.size(), vecs[i].exp_nw);
        end

        // Empty image, then reload and a fresh one-word image from address 0.
        do_reset();
        build_image(16'd0, 32'h0, 32'h0, 1'b1);
        run_image(0, -1);
        pulse_reload();
        check("reload cpu_rst",  cpu_rst,  1);
        check("reload done",     done,     0);
        check("reload in_ready", in_ready, 1);
        build_image(16'd1, 32'h13579BDF, 32'h0, 1'b0);
        run_image(0, -1);

        // Error is sticky across reload and stray bytes; rst clears it.
        do_reset();
        build_image(16'h0101, 32'h0, 32'h0, 1'b1);
        run_image(0, -1);
        pulse_reload();
        @(negedge clock);
        check("sticky error",   error,   1);
        check("sticky cpu_rst", cpu_rst, 1);
        check("sticky ready",   in_ready, 0);
        do_reset();
        check("error cleared", error, 0);

        // rst after five data bytes, then a complete one-word image.
        build_image(16'd2, 32'h11223344, 32'h55667788, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(img[i], 0, dummy);
        do_reset();
        build_image(16'd1, 32'hDEADBEEF, 32'h0, 1'b0);
        run_image(0, -1);
        check("restart write count", wr_log.size(), 1);
        if (wr_log.size() > 0) check("restart wd", wr_log[0].wd, 32'hDEADBEEF);

        // reload pulse mid-DATA has no effect.
        do_reset();
        build_image(16'd3, 32'h0, 32'h0, 1'b1);
        run_image(1, 5);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        build_image(16'd1, 32'h01020304, 32'h0, 1'b0);
        check("chk byte", img[6], 8'h04);
        run_image(0, -1);
        do_reset();
        build_image(16'd1, 32'h01020304, 32'h0, 1'b0);
        img[6] = 8'h05;
        run_image(0, -1);
        check("bad chk error", error, 1);
`endif

        // Random images, chained by reload when the previous one completed.
        for (int t = 0; t < 24; t++) begin
            if (done === 1'b1 && $urandom_range(0, 1) == 1) pulse_reload();
            else do_reset();
            build_image(16'($urandom_range(0, 6)), 32'h0, 32'h0, 1'b1);
`ifdef LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) img[img.size()-1] ^= 8'h01;
`endif
            run_image(int'($urandom_range(0, 5)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 10)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
